// File: rtl/instr_issue_queue.sv
// rtl/instr_issue_queue.sv - FIFO-buffered instruction issuer for the snooping MSI system
// Each instruction is held for HOLD_CYCLES, followed by GAP_CYCLES of NOP.

module instr_issue_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [6:0]                 push_data,
    input  logic                       pop,
    output logic [6:0]                 head,
    output logic [6:0]                 second,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [6:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head   = mem[rd_ptr];
    assign second = mem[rd_ptr + AW'(1)];
endmodule

module instr_issue_queue #(
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 3,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [6:0]                 in_instr,
    input  logic                       pause,
    output logic                       in_ready,
    output logic [6:0]                 instruction,
    output logic                       issue_pulse,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LOAD  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [6:0]    NOP       = 7'b0000000;

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic [GW-1:0] gap_cnt;
    logic          push;
    logic          pop;
    logic          more_after_pop;
    logic          back_to_back;
    logic [6:0]    head;
    logic [6:0]    second;
    logic [6:0]    next_head;

    instr_issue_fifo #(.DEPTH(DEPTH)) fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (in_instr),
        .pop       (pop),
        .head      (head),
        .second    (second),
        .count     (count)
    );

    assign in_ready       = (count < CW'(DEPTH));
    assign push           = in_valid && in_ready && !reset;
    assign pop            = (state == HOLD) && (hold_cnt == '0);
    assign more_after_pop = (count > CW'(1)) || push;
    assign back_to_back   = pop && (GAP_CYCLES == 0) && more_after_pop && !pause;
    // With a single entry left, the follow-on word is being written this very edge.
    assign next_head      = (count == CW'(1)) ? in_instr : second;
    assign busy           = (state != IDLE) || (count != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            gap_cnt     <= '0;
            instruction <= NOP;
            issue_pulse <= 1'b0;
        end else begin
            issue_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (count != '0 && !pause) begin
                        state       <= HOLD;
                        hold_cnt    <= HOLD_LOAD;
                        instruction <= head;
                        issue_pulse <= 1'b1;
                    end
                end
                HOLD: begin
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - HW'(1);
                    end else if (GAP_CYCLES > 0) begin
                        state       <= GAP;
                        gap_cnt     <= GAP_LOAD;
                        instruction <= NOP;
                    end else if (back_to_back) begin
                        hold_cnt    <= HOLD_LOAD;
                        instruction <= next_head;
                        issue_pulse <= 1'b1;
                    end else begin
                        state       <= IDLE;
                        instruction <= NOP;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: begin
                    state       <= IDLE;
                    instruction <= NOP;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_issue_queue.sv
// tb/tb_instr_issue_queue.sv - scoreboard bench for instr_issue_queue
// Two configurations share one stimulus stream: defaults, and HOLD_CYCLES=1/GAP_CYCLES=0.

module tb_instr_issue_queue;
    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [6:0] in_instr;
    logic       pause;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clock = ~clock;

    typedef struct packed {
        logic       rdy;
        logic [6:0] ins;
        logic       pulse;
        logic       bsy;
        logic [3:0] cnt;
    } exp_t;

    task automatic check(input string name, input int ln, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL lane%0d %s: got %0h expected %0h at %0t", ln, name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int H = (g == 0) ? 3 : 1;
        localparam int G = (g == 0) ? 1 : 0;

        logic       in_ready;
        logic       issue_pulse;
        logic       busy;
        logic [6:0] instruction;
        logic [3:0] count;

        instr_issue_queue #(.DEPTH(8), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
            .clock       (clock),
            .reset       (reset),
            .in_valid    (in_valid),
            .in_instr    (in_instr),
            .pause       (pause),
            .in_ready    (in_ready),
            .instruction (instruction),
            .issue_pulse (issue_pulse),
            .busy        (busy),
            .count       (count)
        );

        // Model: a queue of accepted words and the position t within the current
        // instruction slot (0 = idle, 1..H = driving, H+1..H+G = NOP gap).
        logic [6:0] q[$];
        exp_t       exp_q[$];
        int         t = 0;
        logic [6:0] cur;

        always @(posedge clock) begin : model
            int   pre;
            bit   pushed;
            bit   launched;
            exp_t e;
            pre      = q.size();
            pushed   = in_valid && !reset && (pre < 8);
            launched = 0;
            if (reset) begin
                q.delete();
                t = 0;
            end else begin
                if (t == H) void'(q.pop_front());
                if (pushed) q.push_back(in_instr);
                if (t == 0) begin
                    if (pre > 0 && !pause) begin
                        cur = q[0];
                        t = 1;
                        launched = 1;
                    end
                end else if (t < H) begin
                    t++;
                end else if (t == H) begin
                    if (G > 0) t = H + 1;
                    else if (q.size() > 0 && !pause) begin
                        cur = q[0];
                        t = 1;
                        launched = 1;
                    end else t = 0;
                end else if (t < H + G) begin
                    t++;
                end else begin
                    t = 0;
                end
            end
            e.rdy   = (q.size() < 8);
            e.ins   = (t >= 1 && t <= H) ? cur : 7'd0;
            e.pulse = launched;
            e.bsy   = (t != 0) || (q.size() > 0);
            e.cnt   = 4'(q.size());
            exp_q.push_back(e);
        end

        always @(negedge clock) begin : monitor
            exp_t e;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("in_ready", g, 32'(in_ready), 32'(e.rdy));
                check("instruction", g, 32'(instruction), 32'(e.ins));
                check("issue_pulse", g, 32'(issue_pulse), 32'(e.pulse));
                check("busy", g, 32'(busy), 32'(e.bsy));
                check("count", g, 32'(count), 32'(e.cnt));
            end
        end
    end

    task automatic cyc(input logic v, input logic [6:0] w, input logic p, input logic r);
        in_valid = v;
        in_instr = w;
        pause    = p;
        reset    = r;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 7'h00, 1'b0, 1'b0);
    endtask

    initial begin
        bit acc;
        in_valid = 1'b0;
        in_instr = 7'h00;
        pause    = 1'b0;
        reset    = 1'b1;
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 7'h00, 1'b0, 1'b1);
        idle(2);

        // Single word from empty.
        cyc(1'b1, 7'h25, 1'b0, 1'b0);
        idle(10);

        // Fill to full while paused, then offer a ninth word until lane 0 takes it.
        for (int i = 1; i <= 8; i++) cyc(1'b1, 7'(i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 7'h09, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            acc = lane[0].in_ready;
            cyc(1'b1, 7'h09, 1'b0, 1'b0);
            if (acc) break;
        end
        idle(60);

        // Four words queued then released together.
        for (int i = 0; i < 4; i++) cyc(1'b1, 7'(8'h31 + i), 1'b1, 1'b0);
        idle(30);

        // Pause raised mid-HOLD with three queued.
        for (int i = 0; i < 3; i++) cyc(1'b1, 7'(8'h41 + i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 7'h00, 1'b1, 1'b0);
        idle(30);

        // Reset during the second HOLD cycle with five queued.
        for (int i = 0; i < 5; i++) cyc(1'b1, 7'(8'h51 + i), 1'b1, 1'b0);
        cyc(1'b0, 7'h00, 1'b0, 1'b0);
        cyc(1'b0, 7'h00, 1'b0, 1'b0);
        cyc(1'b0, 7'h00, 1'b0, 1'b1);
        cyc(1'b1, 7'h7F, 1'b0, 1'b0);
        idle(12);

        // NOP word between two real instructions.
        cyc(1'b1, 7'h11, 1'b0, 1'b0);
        cyc(1'b1, 7'h00, 1'b0, 1'b0);
        cyc(1'b1, 7'h12, 1'b0, 1'b0);
        idle(25);

        // Randomized traffic with occasional pause and reset.
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 1)), 7'($urandom), $urandom_range(0, 7) == 0,
                $urandom_range(0, 299) == 0);
        end
        idle(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
